div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_div_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter between the integer-divide requester (A)
// and the FPU mantissa-divide requester (B) in front of one iterative divider.
//
// Ports:
//   clk_i, resetn_i              clock, async active-low reset
//   a_req_i .. a_abort_i         requester A (may be signed)
//   b_req_i .. b_abort_i         requester B (always unsigned)
//   a_gnt_o, b_gnt_o             ownership of the divider core
//   a_done_o, b_done_o, err_o    one-cycle completion pulses, err = watchdog
//   res_quot_o, res_rem_o        registered result, valid with a done pulse
//   core_*_o                     command to the iterative divider
//   core_done_i, core_*_i        completion from the iterative divider
//   busy_o                       arbiter is not idle

module div_arbiter #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk_i,
    input  logic        resetn_i,

    input  logic        a_req_i,
    input  logic [31:0] a_dividend_i,
    input  logic [31:0] a_divisor_i,
    input  logic        a_signed_i,
    input  logic        a_abort_i,

    input  logic        b_req_i,
    input  logic [31:0] b_dividend_i,
    input  logic [31:0] b_divisor_i,
    input  logic        b_abort_i,

    output logic        a_gnt_o,
    output logic        b_gnt_o,
    output logic        a_done_o,
    output logic        b_done_o,
    output logic        err_o,
    output logic [31:0] res_quot_o,
    output logic [31:0] res_rem_o,

    output logic        core_start_o,
    output logic        core_abort_o,
    output logic [31:0] core_dividend_o,
    output logic [31:0] core_divisor_o,
    output logic        core_signed_o,

    input  logic        core_done_i,
    input  logic [31:0] core_quot_i,
    input  logic [31:0] core_rem_i,

    output logic        busy_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    // Owner encoding: 0 = requester A, 1 = requester B.
    logic          r_owner;
    logic          r_last;

    logic [31:0]   r_dividend;
    logic [31:0]   r_divisor;
    logic          r_signed;
    logic [31:0]   r_quot;
    logic [31:0]   r_rem;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_any_req;
    logic          w_pick_b;
    logic          w_grant;
    logic          w_own_abort;
    logic          w_abort;
    logic          w_core_ok;
    logic          w_timeout;

    assign w_any_req = a_req_i | b_req_i;

    // On a tie the requester that was not served last wins.
    assign w_pick_b  = b_req_i & (~a_req_i | ~r_last);
    assign w_grant   = (r_state == S_IDLE) & w_any_req;

    assign w_own_abort = r_owner ? b_abort_i : a_abort_i;

    // Only the current grantee can abort, and only before the result exists.
    assign w_abort = w_own_abort
                   & ((r_state == S_START) | (r_state == S_WAIT));

    // Abort beats a same-cycle completion.
    assign w_core_ok = (r_state == S_WAIT) & core_done_i & ~w_abort;

    // A completion arriving on the last allowed cycle is still honoured.
    assign w_timeout = (r_state == S_WAIT) & (r_cnt == CNT_LAST)
                     & ~core_done_i & ~w_abort;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_core_ok | w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and operand capture happen only on the grant.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_pick_b;
            r_last  <= w_pick_b;
            if (w_pick_b) begin
                r_dividend <= b_dividend_i;
                r_divisor  <= b_divisor_i;
                r_signed   <= 1'b0;
            end else begin
                r_dividend <= a_dividend_i;
                r_divisor  <= a_divisor_i;
                r_signed   <= a_signed_i;
            end
        end
    end

    // Watchdog counts cycles spent in WAIT since the start pulse.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
        end else if (r_state == S_START) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Results change only on a real completion or a watchdog expiry.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
        end else if (w_core_ok) begin
            r_quot <= core_quot_i;
            r_rem  <= core_rem_i;
            r_err  <= 1'b0;
        end else if (w_timeout) begin
            r_quot <= '1;
            r_rem  <= r_dividend;
            r_err  <= 1'b1;
        end
    end

    assign busy_o          = (r_state != S_IDLE);
    assign a_gnt_o         = busy_o & ~r_owner;
    assign b_gnt_o         = busy_o & r_owner;

    assign a_done_o        = (r_state == S_RESP) & ~r_owner;
    assign b_done_o        = (r_state == S_RESP) & r_owner;
    assign err_o           = (r_state == S_RESP) & r_err;
    assign res_quot_o      = r_quot;
    assign res_rem_o       = r_rem;

    assign core_start_o    = (r_state == S_START);
    assign core_abort_o    = w_abort | w_timeout;
    assign core_dividend_o = r_dividend;
    assign core_divisor_o  = r_divisor;
    assign core_signed_o   = r_signed;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized transaction bench for div_arbiter with a
// transaction-level arbitration/result model and a behavioural divider core.

module tb_div_arbiter;

    localparam int TO = 48;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        a_req_i, a_signed_i, a_abort_i;
    logic [31:0] a_dividend_i, a_divisor_i;
    logic        b_req_i, b_abort_i;
    logic [31:0] b_dividend_i, b_divisor_i;
    logic        a_gnt_o, b_gnt_o, a_done_o, b_done_o, err_o;
    logic [31:0] res_quot_o, res_rem_o;
    logic        core_start_o, core_abort_o, core_signed_o;
    logic [31:0] core_dividend_o, core_divisor_o;
    logic        core_done_i;
    logic [31:0] core_quot_i, core_rem_i;
    logic        busy_o;

    int          n_checks = 0;
    int          n_errors = 0;

    // Model state: who was served last (1 = B), who is still waiting,
    // and what the result registers should hold.
    bit          last_b = 1'b1;
    bit          pend_a = 1'b0;
    bit          pend_b = 1'b0;
    logic [31:0] exp_q  = '0;
    logic [31:0] exp_r  = '0;

    always #5 clk_i = ~clk_i;

    div_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .a_req_i         (a_req_i),
        .a_dividend_i    (a_dividend_i),
        .a_divisor_i     (a_divisor_i),
        .a_signed_i      (a_signed_i),
        .a_abort_i       (a_abort_i),
        .b_req_i         (b_req_i),
        .b_dividend_i    (b_dividend_i),
        .b_divisor_i     (b_divisor_i),
        .b_abort_i       (b_abort_i),
        .a_gnt_o         (a_gnt_o),
        .b_gnt_o         (b_gnt_o),
        .a_done_o        (a_done_o),
        .b_done_o        (b_done_o),
        .err_o           (err_o),
        .res_quot_o      (res_quot_o),
        .res_rem_o       (res_rem_o),
        .core_start_o    (core_start_o),
        .core_abort_o    (core_abort_o),
        .core_dividend_o (core_dividend_o),
        .core_divisor_o  (core_divisor_o),
        .core_signed_o   (core_signed_o),
        .core_done_i     (core_done_i),
        .core_quot_i     (core_quot_i),
        .core_rem_i      (core_rem_i),
        .busy_o          (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction, entered and left at a negedge with the DUT idle.
    // mode 0: core answers in WAIT cycle k
    // mode 1: grantee aborts in WAIT cycle k (k = 0: in START)
    // mode 2: core never answers, watchdog fires
    task automatic run_op(input bit ra_in, input bit rb_in,
                          input logic [31:0] ad, input logic [31:0] av,
                          input bit as_, input logic [31:0] bd,
                          input logic [31:0] bv, input int mode,
                          input int k);
        bit          ra, rb, g, sg;
        logic [31:0] dd, dv, q, r;
        ra = ra_in | pend_a;
        rb = rb_in | pend_b;
        if (!ra && !rb) ra = 1'b1;
        g      = (ra && rb) ? !last_b : rb;
        last_b = g;
        dd     = g ? bd : ad;
        dv     = g ? bv : av;
        sg     = g ? 1'b0 : as_;
        if (sg) begin
            q = $signed(dd) / $signed(dv);
            r = $signed(dd) % $signed(dv);
        end else begin
            q = dd / dv;
            r = dd % dv;
        end

        chk("idle_busy", 32'(busy_o), 0);
        a_req_i      = ra;
        b_req_i      = rb;
        a_dividend_i = ad;
        a_divisor_i  = av;
        a_signed_i   = as_;
        b_dividend_i = bd;
        b_divisor_i  = bv;
        core_done_i  = 1'($urandom_range(0, 1));
        core_quot_i  = $urandom;
        core_rem_i   = $urandom;

        @(negedge clk_i);
        core_done_i = 1'($urandom_range(0, 1));
        chk("start", 32'(core_start_o), 1);
        chk("start_gnt_a", 32'(a_gnt_o), 32'(!g));
        chk("start_gnt_b", 32'(b_gnt_o), 32'(g));
        chk("op_dividend", core_dividend_o, dd);
        chk("op_divisor", core_divisor_o, dv);
        chk("op_signed", 32'(core_signed_o), 32'(sg));
        if (g) b_req_i = 1'b0;
        else   a_req_i = 1'b0;
        pend_a = a_req_i;
        pend_b = b_req_i;
        if (g) b_dividend_i = $urandom;
        else   a_dividend_i = $urandom;

        if (mode == 1 && k == 0) begin
            if (g) b_abort_i = 1'b1;
            else   a_abort_i = 1'b1;
            #1 chk("abort_start", 32'(core_abort_o), 1);
            @(negedge clk_i);
            core_done_i = 1'b0;
            a_abort_i   = 1'b0;
            b_abort_i   = 1'b0;
            chk("ab_busy", 32'(busy_o), 0);
            chk("ab_done", 32'(a_done_o | b_done_o), 0);
            chk("ab_quot", res_quot_o, exp_q);
            return;
        end

        for (int w = 1; w <= TO; w++) begin
            @(negedge clk_i);
            core_done_i = 1'b0;
            if (g) a_abort_i = 1'($urandom_range(0, 1));
            else   b_abort_i = 1'($urandom_range(0, 1));
            chk("wait_dividend", core_dividend_o, dd);
            chk("wait_gnt", 32'(g ? b_gnt_o : a_gnt_o), 1);
            if (mode == 0 && w == k) begin
                core_done_i = 1'b1;
                core_quot_i = q;
                core_rem_i  = r;
                #1 chk("wait_no_abort", 32'(core_abort_o), 0);
                break;
            end
            if (mode == 1 && w == k) begin
                if (g) b_abort_i = 1'b1;
                else   a_abort_i = 1'b1;
                core_done_i = 1'($urandom_range(0, 1));
                #1 chk("abort_wait", 32'(core_abort_o), 1);
                break;
            end
            #1 chk("wait_abort", 32'(core_abort_o),
                   32'(mode == 2 && w == TO));
        end

        @(negedge clk_i);
        core_done_i = 1'b0;
        a_abort_i   = 1'b0;
        b_abort_i   = 1'b0;
        if (mode == 1) begin
            chk("ab_busy", 32'(busy_o), 0);
            chk("ab_done", 32'(a_done_o | b_done_o), 0);
            chk("ab_quot", res_quot_o, exp_q);
            chk("ab_rem", res_rem_o, exp_r);
            return;
        end
        if (mode == 2) begin
            exp_q = '1;
            exp_r = dd;
        end else begin
            exp_q = q;
            exp_r = r;
        end
        chk("resp_done_a", 32'(a_done_o), 32'(!g));
        chk("resp_done_b", 32'(b_done_o), 32'(g));
        chk("resp_err", 32'(err_o), 32'(mode == 2));
        chk("resp_quot", res_quot_o, exp_q);
        chk("resp_rem", res_rem_o, exp_r);
        chk("resp_gnt", 32'(g ? b_gnt_o : a_gnt_o), 1);

        @(negedge clk_i);
        chk("post_done", 32'(a_done_o | b_done_o), 0);
        chk("post_busy", 32'(busy_o), 0);
    endtask

    initial begin
        resetn_i     = 1'b0;
        a_req_i      = 1'b0;
        a_dividend_i = '0;
        a_divisor_i  = '0;
        a_signed_i   = 1'b0;
        a_abort_i    = 1'b0;
        b_req_i      = 1'b0;
        b_dividend_i = '0;
        b_divisor_i  = '0;
        b_abort_i    = 1'b0;
        core_done_i  = 1'b0;
        core_quot_i  = '0;
        core_rem_i   = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_gnt", 32'({a_gnt_o, b_gnt_o}), 0);
        chk("rst_done", 32'({a_done_o, b_done_o, err_o}), 0);
        chk("rst_core", 32'({core_start_o, core_abort_o, core_signed_o}), 0);
        chk("rst_quot", res_quot_o, 0);
        chk("rst_rem", res_rem_o, 0);
        chk("rst_dividend", core_dividend_o, 0);
        resetn_i = 1'b1;
        @(negedge clk_i);

        // A alone, 100/7 answered 32 cycles after start.
        run_op(1, 0, 100, 7, 0, 0, 1, 0, 32);
        chk("div100_quot", res_quot_o, 14);
        chk("div100_rem", res_rem_o, 2);

        // Ties from reset: A, then waiting B, then A again.
        run_op(1, 1, 32'd50, 32'd5, 0, 32'd81, 32'd9, 0, 10);
        run_op(0, 0, 32'd1, 32'd1, 0, 32'd81, 32'd9, 0, 3);
        run_op(1, 1, 32'hFFFF_FF9C, 32'd7, 1, 32'd9, 32'd2, 0, 4);

        // B wins the tie, aborts in WAIT cycle 5, waiting A is served next.
        run_op(1, 1, 32'd77, 32'd3, 0, 32'd500, 32'd7, 1, 5);
        run_op(0, 0, 32'd77, 32'd3, 0, 32'd500, 32'd7, 0, 6);

        // Watchdog.
        run_op(1, 0, 32'h1234_5678, 32'd3, 0, 32'd1, 32'd1, 2, 0);
        chk("wd_quot", res_quot_o, 32'hFFFF_FFFF);
        chk("wd_rem", res_rem_o, 32'h1234_5678);

        for (int i = 0; i < 40; i++) begin
            int          p, m, kk;
            bit          s;
            logic [31:0] av, bv;
            p = $urandom_range(0, 9);
            if (p < 7) begin
                m  = 0;
                kk = $urandom_range(1, 40);
            end else if (p < 9) begin
                m  = 1;
                kk = $urandom_range(0, 10);
            end else begin
                m  = 2;
                kk = 0;
            end
            s  = 1'($urandom_range(0, 1));
            av = $urandom_range(2, 1000);
            if (s && $urandom_range(0, 1) == 1) av = -av;
            bv = $urandom_range(1, 1 << 20);
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, av, s, $urandom, bv, m, kk);
        end

        // Reset in the middle of WAIT.
        a_req_i      = 1'b1;
        b_req_i      = 1'b0;
        a_dividend_i = 32'd999;
        a_divisor_i  = 32'd3;
        a_signed_i   = 1'b0;
        @(negedge clk_i);
        a_req_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("pre_rst_busy", 32'(busy_o), 1);
        #2 resetn_i = 1'b0;
        #1;
        chk("arst_gnt", 32'({a_gnt_o, b_gnt_o}), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_abort", 32'(core_abort_o), 0);
        chk("arst_done", 32'({a_done_o, b_done_o}), 0);
        chk("arst_quot", res_quot_o, 0);
        last_b = 1'b1;
        pend_a = 1'b0;
        pend_b = 1'b0;
        exp_q  = '0;
        exp_r  = '0;
        @(negedge clk_i);
        resetn_i = 1'b1;
        @(negedge clk_i);
        run_op(1, 1, 32'd1000, 32'd9, 0, 32'd64, 32'd8, 0, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
